// File: rtl/key_event_fifo.sv
// Small event queue between the key decoder and the text buffer: one event per cycle in, registered pulses out.
// Full-queue policy: define KEY_EVENT_FIFO_DROP_OLDEST_EN to discard the head instead of the newcomer.
module key_event_fifo #(
    parameter int SYMBOL_WIDTH = 7,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       left_in,
    input  logic                       right_in,
    input  logic                       backspace_in,
    input  logic [SYMBOL_WIDTH-1:0]    symbol_in,
    output logic                       left_out,
    output logic                       right_out,
    output logic                       backspace_out,
    output logic [SYMBOL_WIDTH-1:0]    symbol_out,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] KIND_SYM  = 2'd0;
    localparam logic [1:0] KIND_LEFT = 2'd1;
    localparam logic [1:0] KIND_RGHT = 2'd2;
    localparam logic [1:0] KIND_BKSP = 2'd3;

    logic [1:0]              kind_mem [DEPTH];
    logic [SYMBOL_WIDTH-1:0] sym_mem  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic                    vld_p0;
    logic [1:0]              kind_p0;
    logic [SYMBOL_WIDTH-1:0] sym_p0;
    logic [3:0]              events_p0;
    logic                    collision_p0;

    logic full;
    logic pop;
    logic do_write;
    logic drop_head;
    logic lost_new;
    logic adv_rd;

    // Stage p0: pick the single highest-priority event of this cycle
    always_comb begin
        vld_p0       = 1'b0;
        kind_p0      = KIND_SYM;
        sym_p0       = '0;
        events_p0    = {backspace_in, left_in, right_in, |symbol_in};
        collision_p0 = (events_p0 & (events_p0 - 4'd1)) != 4'd0;
        if (backspace_in) begin
            vld_p0  = 1'b1;
            kind_p0 = KIND_BKSP;
        end else if (left_in) begin
            vld_p0  = 1'b1;
            kind_p0 = KIND_LEFT;
        end else if (right_in) begin
            vld_p0  = 1'b1;
            kind_p0 = KIND_RGHT;
        end else if (|symbol_in) begin
            vld_p0  = 1'b1;
            kind_p0 = KIND_SYM;
            sym_p0  = symbol_in;
        end
    end

    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0) && out_ready;

`ifdef KEY_EVENT_FIFO_DROP_OLDEST_EN
    // When full, wr_ptr == rd_ptr, so writing there overwrites exactly the head being discarded
    assign drop_head = vld_p0 && full && !pop;
    assign do_write  = vld_p0;
    assign lost_new  = 1'b0;
`else
    assign drop_head = 1'b0;
    assign do_write  = vld_p0 && (!full || pop);
    assign lost_new  = vld_p0 && full && !pop;
`endif

    assign adv_rd = pop || drop_head;

    // Storage is never reset; only pointers and count decide what is valid
    always_ff @(posedge clk) begin
        if (do_write) begin
            kind_mem[wr_ptr] <= kind_p0;
            sym_mem[wr_ptr]  <= sym_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, adv_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (collision_p0 || lost_new || drop_head) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stage p1: registered output pulses, one cycle per popped event
    always_ff @(posedge clk) begin
        if (rst) begin
            left_out      <= 1'b0;
            right_out     <= 1'b0;
            backspace_out <= 1'b0;
            symbol_out    <= '0;
        end else begin
            left_out      <= 1'b0;
            right_out     <= 1'b0;
            backspace_out <= 1'b0;
            symbol_out    <= '0;
            if (pop) begin
                case (kind_mem[rd_ptr])
                    KIND_LEFT: left_out      <= 1'b1;
                    KIND_RGHT: right_out     <= 1'b1;
                    KIND_BKSP: backspace_out <= 1'b1;
                    default:   symbol_out    <= sym_mem[rd_ptr];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo (DEPTH=4, SYMBOL_WIDTH=7).
// Expected delivery order on overflow follows KEY_EVENT_FIFO_DROP_OLDEST_EN.
module tb_key_event_fifo;

    logic       clk;
    logic       rst;
    logic       left_in;
    logic       right_in;
    logic       backspace_in;
    logic [6:0] symbol_in;
    logic       out_ready;
    logic       left_out;
    logic       right_out;
    logic       backspace_out;
    logic [6:0] symbol_out;
    logic [2:0] count;
    logic       overflow;

    int total;
    int passed;

    logic [9:0] outs;
    assign outs = {left_out, right_out, backspace_out, symbol_out};

    key_event_fifo #(.SYMBOL_WIDTH(7), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .left_in(left_in), .right_in(right_in), .backspace_in(backspace_in),
        .symbol_in(symbol_in),
        .left_out(left_out), .right_out(right_out), .backspace_out(backspace_out),
        .symbol_out(symbol_out),
        .out_ready(out_ready), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        left_in = 1'b0; right_in = 1'b0; backspace_in = 1'b0; symbol_in = 7'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        left_in = 1'b1; symbol_in = 7'h41; out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else passed++;
        total++; if (outs !== 10'h0) $display("FAIL reset_outs got %h want 000", outs); else passed++;
    endtask

    task automatic test_single_symbol;
        do_reset();
        out_ready = 1'b1;
        symbol_in = 7'h78;
        tick();
        symbol_in = 7'h0;
        total++; if (count !== 3'd1) $display("FAIL single_count1 got %0d want 1", count); else passed++;
        total++; if (outs !== 10'h0) $display("FAIL single_early got %h want 000", outs); else passed++;
        tick();
        total++; if (outs !== {3'b000, 7'h78}) $display("FAIL single_out got %h want %h", outs, {3'b000, 7'h78}); else passed++;
        total++; if (count !== 3'd0) $display("FAIL single_count0 got %0d want 0", count); else passed++;
        tick();
        total++; if (outs !== 10'h0) $display("FAIL single_pulse_len got %h want 000", outs); else passed++;
    endtask

    task automatic test_burst;
        logic [6:0] syms [4];
        syms[0] = 7'h5B; syms[1] = 7'h78; syms[2] = 7'h2D; syms[3] = 7'h35;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            symbol_in = syms[i];
            tick();
        end
        symbol_in = 7'h0;
        total++; if (count !== 3'd4) $display("FAIL burst_full got %0d want 4", count); else passed++;
        total++; if (outs !== 10'h0) $display("FAIL burst_held got %h want 000", outs); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (outs !== {3'b000, syms[i]}) $display("FAIL burst_out%0d got %h want %h", i, outs, {3'b000, syms[i]}); else passed++;
            total++; if (count !== 3'(3 - i)) $display("FAIL burst_count%0d got %0d want %0d", i, count, 3 - i); else passed++;
        end
        tick();
        total++; if (outs !== 10'h0) $display("FAIL burst_drained got %h want 000", outs); else passed++;
    endtask

    task automatic test_overflow_full;
        logic [6:0] exp [4];
`ifdef KEY_EVENT_FIFO_DROP_OLDEST_EN
        exp[0] = 7'h32; exp[1] = 7'h33; exp[2] = 7'h34; exp[3] = 7'h35;
`else
        exp[0] = 7'h31; exp[1] = 7'h32; exp[2] = 7'h33; exp[3] = 7'h34;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            symbol_in = 7'(7'h31 + i);
            tick();
        end
        total++; if (overflow !== 1'b0) $display("FAIL ovf_before got %0b want 0", overflow); else passed++;
        symbol_in = 7'h35;
        tick();
        symbol_in = 7'h0;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow); else passed++;
        total++; if (count !== 3'd4) $display("FAIL ovf_count got %0d want 4", count); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (outs !== {3'b000, exp[i]}) $display("FAIL ovf_out%0d got %h want %h", i, outs, {3'b000, exp[i]}); else passed++;
        end
        tick();
        total++; if (outs !== 10'h0) $display("FAIL ovf_extra got %h want 000", outs); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", overflow); else passed++;
    endtask

    task automatic test_priority;
        do_reset();
        out_ready = 1'b1;
        left_in = 1'b1; symbol_in = 7'h61;
        tick();
        idle_inputs();
        total++; if (overflow !== 1'b1) $display("FAIL prio_overflow got %0b want 1", overflow); else passed++;
        total++; if (count !== 3'd1) $display("FAIL prio_count got %0d want 1", count); else passed++;
        tick();
        total++; if (outs !== {3'b100, 7'h0}) $display("FAIL prio_left got %h want %h", outs, {3'b100, 7'h0}); else passed++;
        tick();
        total++; if (outs !== 10'h0) $display("FAIL prio_no_symbol got %h want 000", outs); else passed++;
        do_reset();
        out_ready = 1'b1;
        backspace_in = 1'b1; left_in = 1'b1; right_in = 1'b1;
        tick();
        idle_inputs();
        tick();
        total++; if (outs !== {3'b001, 7'h0}) $display("FAIL prio_bksp got %h want %h", outs, {3'b001, 7'h0}); else passed++;
    endtask

    task automatic test_full_push_pop;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            symbol_in = 7'(7'h31 + i);
            tick();
        end
        out_ready = 1'b1;
        symbol_in = 7'h39;
        tick();
        symbol_in = 7'h0;
        total++; if (count !== 3'd4) $display("FAIL fpp_count got %0d want 4", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fpp_overflow got %0b want 0", overflow); else passed++;
        total++; if (outs !== {3'b000, 7'h31}) $display("FAIL fpp_first got %h want %h", outs, {3'b000, 7'h31}); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) begin
                total++; if (outs !== {3'b000, 7'(7'h32 + i)}) $display("FAIL fpp_mid%0d got %h want %h", i, outs, {3'b000, 7'(7'h32 + i)}); else passed++;
            end else begin
                total++; if (outs !== {3'b000, 7'h39}) $display("FAIL fpp_last got %h want %h", outs, {3'b000, 7'h39}); else passed++;
            end
        end
        total++; if (count !== 3'd0) $display("FAIL fpp_empty got %0d want 0", count); else passed++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        out_ready = 1'b1;
        backspace_in = 1'b1;
        tick();
        idle_inputs(); right_in = 1'b1;
        tick();
        total++; if (outs !== {3'b001, 7'h0}) $display("FAIL b2b_bksp got %h want %h", outs, {3'b001, 7'h0}); else passed++;
        total++; if (count !== 3'd1) $display("FAIL b2b_count got %0d want 1", count); else passed++;
        idle_inputs(); left_in = 1'b1;
        tick();
        total++; if (outs !== {3'b010, 7'h0}) $display("FAIL b2b_right got %h want %h", outs, {3'b010, 7'h0}); else passed++;
        idle_inputs(); symbol_in = 7'h71;
        tick();
        total++; if (outs !== {3'b100, 7'h0}) $display("FAIL b2b_left got %h want %h", outs, {3'b100, 7'h0}); else passed++;
        idle_inputs();
        tick();
        total++; if (outs !== {3'b000, 7'h71}) $display("FAIL b2b_sym got %h want %h", outs, {3'b000, 7'h71}); else passed++;
        tick();
        total++; if (outs !== 10'h0) $display("FAIL b2b_idle got %h want 000", outs); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow got %0b want 0", overflow); else passed++;
    endtask

    task automatic test_reset_flush;
        int pulses;
        do_reset();
        backspace_in = 1'b1; tick(); idle_inputs();
        symbol_in = 7'h62; tick();
        right_in = 1'b1; symbol_in = 7'h0; tick();
        idle_inputs();
        total++; if (count !== 3'd3) $display("FAIL flush_pre got %0d want 3", count); else passed++;
        symbol_in = 7'h78;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        total++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL flush_overflow got %0b want 0", overflow); else passed++;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (outs !== 10'h0) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL flush_pulses got %0d want 0", pulses); else passed++;
        total++; if (count !== 3'd0) $display("FAIL flush_final got %0d want 0", count); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_single_symbol();
        test_burst();
        test_overflow_full();
        test_priority();
        test_full_push_pop();
        test_back_to_back();
        test_reset_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 7: symbol code width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of queued events; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports left_in, right_in and backspace_in, each input, 1 bit: one-cycle key-event pulses.
REQ-006 SHALL have port symbol_in, input, SYMBOL_WIDTH bits: symbol event when nonzero; 0 means no symbol.
REQ-007 SHALL have ports left_out, right_out and backspace_out, each output, 1 bit: registered one-cycle event pulses.
REQ-008 SHALL have port symbol_out, output, SYMBOL_WIDTH bits: registered symbol, nonzero for one cycle per event.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer (text_buffer) can accept an event this cycle.
REQ-010 SHALL have port count, output, $clog2(DEPTH+1) bits: number of events currently queued.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag; an event was lost.

Function
REQ-012 Each queue entry SHALL hold a 2-bit kind (0 symbol, 1 left, 2 right, 3 backspace) plus a SYMBOL_WIDTH payload.
REQ-013 Input event detection: backspace_in > left_in > right_in > symbol_in!=0, in that priority order.
REQ-014 At most one event SHALL be pushed per cycle; lower-priority simultaneous inputs SHALL be dropped and SHALL set overflow.
REQ-015 Push: a detected event SHALL be written at the rising edge of its cycle N and SHALL be counted in count from cycle N+1.
REQ-016 Pop: when count>0 and out_ready=1 in cycle M, the head SHALL be removed at that edge.
REQ-017 The popped event SHALL be driven on exactly one output in cycle M+1; all outputs SHALL be 0 otherwise.
REQ-018 Minimum input-to-output latency SHALL be 2 cycles; there is no bypass, even when the queue is empty.
REQ-019 Push and pop in the same cycle SHALL both take effect; count SHALL be unchanged.
REQ-020 Full (count==DEPTH) with a push and no pop: the behaviour SHALL be as defined in REQ-030/031, and overflow SHALL be set.
REQ-021 Full with a simultaneous push and pop SHALL accept the push, leave count==DEPTH and not set overflow.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH without a gap.
REQ-023 Events SHALL be delivered in FIFO order; no event SHALL be duplicated.
REQ-024 overflow SHALL stay high until rst.

Reset
REQ-025 rst SHALL clear the pointers, count and overflow, and all *_out outputs SHALL be 0 in the cycle after rst.
REQ-026 rst SHALL take priority over any push or pop in the same cycle; the event from that cycle SHALL be discarded.
REQ-027 rst asserted mid-stream SHALL flush all queued events; none SHALL appear on the outputs afterwards.
REQ-028 The queue storage itself SHALL NOT need clearing on reset.

Configuration
REQ-029 The macro KEY_EVENT_FIFO_DROP_OLDEST_EN SHALL select the full-queue policy.
REQ-030 With the macro defined, a push to a full queue with no pop SHALL discard the head and append the new event; count stays DEPTH.
REQ-031 Without the macro, a push to a full queue with no pop SHALL discard the new event; the queue is unchanged.
REQ-032 overflow SHALL be set in both builds whenever an event is lost.

Verification
REQ-033 Reset, then symbol_in="x" for 1 cycle with out_ready=1 -> symbol_out=="x" exactly 2 cycles later, for 1 cycle; count returns to 0.
REQ-034 With out_ready=0, push "[", "x", "-", "5", then raise out_ready -> outputs "[", "x", "-", "5" on 4 consecutive cycles; count goes 4,3,2,1,0.
REQ-035 With DEPTH=4 and out_ready=0, push 5 symbols "1".."5" -> overflow=1; delivered "1".."4" by default, or "2".."5" with KEY_EVENT_FIFO_DROP_OLDEST_EN.
REQ-036 left_in=1 and symbol_in="a" in the same cycle -> only a left_out pulse is delivered; overflow=1.
REQ-037 Queue full with out_ready=1 and a push of "9" in the same cycle -> count stays 4, overflow stays 0, and "9" is delivered last.
REQ-038 Push 3 events, assert rst for 1 cycle with a push in the same cycle -> count=0, overflow=0, no output pulses for 10 cycles.
